// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every handshake/bus signal around mem_port_arbiter: the CPU
// instruction-fetch requester, the data load/store requester and the
// single-port memory bus.
//   modport slave  : arbiter view (takes requests and memory responses,
//                    drives grants, read returns and the memory request).
//   modport master : environment view (CPU core plus memory model).
// Signals:
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata          fetch side
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt, d_rvalid, d_rdata   data side
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ack, mem_rdata  memory
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory bus between the instruction-fetch requester
// and the data load/store requester. One transaction is in flight at a time:
// IDLE picks a winner (data beats fetch), latches its payload onto mem_* and
// pulses its gnt; BUSY_IF/BUSY_D hold mem_* until mem_ack, then return the
// read data (0 for stores) with a one-cycle rvalid and go back to IDLE.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset; drops any in-flight transaction
//   bus  - mem_port_arbiter_if.slave (fetch, data and memory signals)
// Optional feature, macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
// data grants issued while fetch was waiting, fetch wins the next contested
// arbitration. Without the macro data priority is strict.
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t            state_r,     state_s;
    logic              if_gnt_r,    if_gnt_s;
    logic              d_gnt_r,     d_gnt_s;
    logic              if_rvalid_r, if_rvalid_s;
    logic              d_rvalid_r,  d_rvalid_s;
    logic [DATA_W-1:0] if_rdata_r,  if_rdata_s;
    logic [DATA_W-1:0] d_rdata_r,   d_rdata_s;
    logic              mem_req_r,   mem_req_s;
    logic              mem_we_r,    mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic [BE_W-1:0]   mem_be_r,    mem_be_s;

    logic pick_d_s;
    logic pick_if_s;
    logic fetch_turn_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_r, starve_cnt_s;

    // Fetch takes the turn once data has been granted STARVE_MAX times in a row over it.
    always_comb begin
        fetch_turn_s = (starve_cnt_r == CNT_W'(STARVE_MAX));
    end

    // Starvation count: cleared by any fetch grant, bumped by data grants that made fetch wait.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if ((state_r == IDLE) && pick_if_s) begin
            starve_cnt_s = {CNT_W{1'b0}};
        end else if ((state_r == IDLE) && pick_d_s && bus.if_req && !fetch_turn_s) begin
            starve_cnt_s = starve_cnt_r + CNT_W'(1'b1);
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_s;
        end
    end
`else
    // Strict data priority: fetch never takes the turn. The comparison is
    // always false; it keeps STARVE_MAX referenced so both builds share one
    // parameter list.
    always_comb begin
        fetch_turn_s = (STARVE_MAX < 32'sd0);
    end
`endif

    // Winner selection among pending requests; only acted on in IDLE.
    always_comb begin
        pick_d_s  = 1'b0;
        pick_if_s = 1'b0;
        if (bus.d_req && !(bus.if_req && fetch_turn_s)) begin
            pick_d_s = 1'b1;
        end else if (bus.if_req) begin
            pick_if_s = 1'b1;
        end else begin
            pick_d_s  = 1'b0;
            pick_if_s = 1'b0;
        end
    end

    // Next-state and next-output logic; gnt/rvalid default low so they pulse.
    always_comb begin
        state_s     = state_r;
        if_gnt_s    = 1'b0;
        d_gnt_s     = 1'b0;
        if_rvalid_s = 1'b0;
        d_rvalid_s  = 1'b0;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_be_s    = mem_be_r;
        case (state_r)
            IDLE: begin
                if (pick_d_s) begin
                    d_gnt_s     = 1'b1;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.d_we;
                    mem_addr_s  = bus.d_addr;
                    mem_wdata_s = bus.d_wdata;
                    // Loads read the full word; only stores use the requester's enables.
                    mem_be_s    = bus.d_we ? bus.d_be : {BE_W{1'b1}};
                    state_s     = BUSY_D;
                end else if (pick_if_s) begin
                    if_gnt_s    = 1'b1;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.if_addr;
                    mem_wdata_s = {DATA_W{1'b0}};
                    mem_be_s    = {BE_W{1'b1}};
                    state_s     = BUSY_IF;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    if_rdata_s  = bus.mem_rdata;
                    if_rvalid_s = 1'b1;
                    mem_req_s   = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = BUSY_IF;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    d_rdata_s  = mem_we_r ? {DATA_W{1'b0}} : bus.mem_rdata;
                    d_rvalid_s = 1'b1;
                    mem_req_s  = 1'b0;
                    state_s    = IDLE;
                end else begin
                    state_s = BUSY_D;
                end
            end
            default: begin
                mem_req_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers; async reset also drops mem_req mid-transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            if_gnt_r    <= 1'b0;
            d_gnt_r     <= 1'b0;
            if_rvalid_r <= 1'b0;
            d_rvalid_r  <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
        end else begin
            state_r     <= state_s;
            if_gnt_r    <= if_gnt_s;
            d_gnt_r     <= d_gnt_s;
            if_rvalid_r <= if_rvalid_s;
            d_rvalid_r  <= d_rvalid_s;
            if_rdata_r  <= if_rdata_s;
            d_rdata_r   <= d_rdata_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_be_r    <= mem_be_s;
        end
    end

    assign bus.if_gnt    = if_gnt_r;
    assign bus.d_gnt     = d_gnt_r;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.d_rvalid  = d_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_be    = mem_be_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed steps followed by a randomized phase. A transaction-level reference
// model (who owns the bus, which payload was granted, what data each requester
// should hold) predicts every cycle's outputs from the arbitration rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state: owner 0 = none, 1 = fetch, 2 = data.
    int          owner;
    int          streak;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; streak = 0;
        m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0;
        m_if_rdata = 32'h0; m_d_rdata = 32'h0;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
    endtask

    // Predict what the coming clock edge does, from the inputs currently driven.
    task automatic model_edge();
        bit fetch_first;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
        fetch_first = GUARD && bus.if_req && (streak >= STARVE_MAX);
        if (!rst) begin
            model_reset();
        end else if (owner == 0) begin
            if (bus.d_req && !fetch_first) begin
                e_d_gnt = 1'b1; owner = 2;
                m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                m_be = bus.d_we ? bus.d_be : 4'hF;
                if (bus.if_req && streak < STARVE_MAX) streak++;
            end else if (bus.if_req) begin
                e_if_gnt = 1'b1; owner = 1;
                m_we = 1'b0; m_addr = bus.if_addr; m_be = 4'hF;
                streak = 0;
            end
        end else if (bus.mem_ack) begin
            if (owner == 1) begin
                e_if_rv = 1'b1; m_if_rdata = bus.mem_rdata;
            end else begin
                e_d_rv = 1'b1; m_d_rdata = m_we ? 32'h0 : bus.mem_rdata;
            end
            owner = 0;
        end
    endtask

    // One clock: predict, clock, then compare all outputs 1 ns after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("if_gnt",    bus.if_gnt,    e_if_gnt);
        chk("d_gnt",     bus.d_gnt,     e_d_gnt);
        chk("if_rvalid", bus.if_rvalid, e_if_rv);
        chk("d_rvalid",  bus.d_rvalid,  e_d_rv);
        chk("mem_req",   bus.mem_req,   (owner != 0));
        chk("if_rdata",  bus.if_rdata,  m_if_rdata);
        chk("d_rdata",   bus.d_rdata,   m_d_rdata);
        if (owner != 0) begin
            chk("mem_we",   bus.mem_we,   m_we);
            chk("mem_addr", bus.mem_addr, m_addr);
            chk("mem_be",   bus.mem_be,   m_be);
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
    endtask

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        bus.d_wdata = 32'h0; bus.d_be = 4'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   pat [10];
        int   n_gnt;
        int   k;
        bit   if_wait;
        bit   d_wait;
        logic [31:0] rd;

        // Reset with all requests low, then 10 quiet cycles.
        idle_inputs();
        model_reset();
        rst = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        repeat (10) cycle();
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_mem_we",    bus.mem_we,    1'b0);
        chk("rst_mem_be",    bus.mem_be,    4'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

        // Single fetch; memory answers two cycles after mem_req rises.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
        cycle();
        chk("f1_gnt",  bus.if_gnt,   1'b1);
        chk("f1_addr", bus.mem_addr, 32'h10);
        chk("f1_be",   bus.mem_be,   4'hF);
        chk("f1_we",   bus.mem_we,   1'b0);
        bus.if_req = 1'b0;
        cycle();
        cycle();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
        cycle();
        bus.mem_ack = 1'b0;
        chk("f1_rvalid", bus.if_rvalid, 1'b1);
        chk("f1_rdata",  bus.if_rdata,  32'h0050_0093);

        // Simultaneous fetch and store: data first, fetch two cycles after ack.
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0020;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100;
        bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'h3;
        cycle();
        chk("s1_dgnt",  bus.d_gnt,     1'b1);
        chk("s1_ifgnt", bus.if_gnt,    1'b0);
        chk("s1_we",    bus.mem_we,    1'b1);
        chk("s1_be",    bus.mem_be,    4'h3);
        chk("s1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        cycle();
        bus.mem_ack = 1'b0;
        chk("s1_rvalid", bus.d_rvalid, 1'b1);
        chk("s1_rdata",  bus.d_rdata,  32'h0);
        chk("s1_ifrd",   bus.if_rdata, 32'h0050_0093);
        cycle();
        chk("s1_late_ifgnt", bus.if_gnt, 1'b1);
        bus.if_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
        cycle();
        bus.mem_ack = 1'b0;

        // Reset while a load is in flight.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        cycle();
        bus.d_req = 1'b0;
        chk("r1_busy", bus.mem_req, 1'b1);
        cycle();
        #2 rst = 1'b0;
        #1;
        chk("r1_async_memreq", bus.mem_req, 1'b0);
        model_reset();
        cycle();
        rst = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        cycle();
        bus.mem_ack = 1'b0;
        chk("r1_no_rvalid", bus.d_rvalid, 1'b0);
        cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        cycle();
        chk("r1_ifgnt", bus.if_gnt, 1'b1);
        bus.if_req = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0ABC_DEF0;
        cycle();
        bus.mem_ack = 1'b0;
        chk("r1_ifrdata", bus.if_rdata, 32'h0ABC_DEF0);

        // Starvation: both requesters held, memory acks at once.
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        n_gnt = 0; k = 0;
        while (n_gnt < 10 && k < 60) begin
            bus.mem_ack = bus.mem_req; bus.mem_rdata = $urandom;
            cycle();
            if (bus.if_gnt && n_gnt < 10) begin pat[n_gnt] = 1'b1; n_gnt++; end
            if (bus.d_gnt && n_gnt < 10) begin pat[n_gnt] = 1'b0; n_gnt++; end
            k++;
        end
        chk("st_count", n_gnt, 10);
        for (int i = 0; i < n_gnt; i++) begin
            chk($sformatf("st_pat%0d", i), pat[i],
                GUARD && ((i % (STARVE_MAX + 1)) == STARVE_MAX));
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (4) begin
            bus.mem_ack = bus.mem_req; bus.mem_rdata = $urandom;
            cycle();
        end

        // Spurious mem_ack while idle for three cycles.
        repeat (3) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = $urandom;
            cycle();
            chk("sp_if_rvalid", bus.if_rvalid, 1'b0);
            chk("sp_d_rvalid",  bus.d_rvalid,  1'b0);
        end
        bus.mem_ack = 1'b0;

        // Randomized traffic with withdrawals, random ack delays and stray acks.
        if_wait = 1'b0; d_wait = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (bus.if_gnt) begin
                bus.if_req = 1'b0; if_wait = 1'b1;
            end else if (bus.if_req && $urandom_range(0, 15) == 0) begin
                bus.if_req = 1'b0;
            end
            if (bus.if_rvalid) if_wait = 1'b0;
            if (!bus.if_req && !if_wait && !bus.if_gnt && $urandom_range(0, 3) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (bus.d_gnt) begin
                bus.d_req = 1'b0; d_wait = 1'b1;
            end else if (bus.d_req && $urandom_range(0, 15) == 0) begin
                bus.d_req = 1'b0;
            end
            if (bus.d_rvalid) d_wait = 1'b0;
            if (!bus.d_req && !d_wait && !bus.d_gnt && $urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = $urandom; bus.d_wdata = $urandom;
                bus.d_be = 4'($urandom_range(0, 15));
            end
            rd = $urandom;
            bus.mem_rdata = rd;
            if (bus.mem_req) bus.mem_ack = ($urandom_range(0, 2) == 0);
            else             bus.mem_ack = ($urandom_range(0, 9) == 0);
            cycle();
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (8) begin
            bus.mem_ack = bus.mem_req; bus.mem_rdata = $urandom;
            cycle();
        end
        chk("end_idle", bus.mem_req, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory bus between the CPU instruction-fetch requester and the data load/store requester.
- Accepts one transaction at a time and forwards it to the memory port.
- Waits for the memory acknowledge, then returns read data or write completion to the requester that owns the transaction.
- Sits between the cpu core's fetch/LSU interfaces and the unified memory model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request; held until if_gnt is seen.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction word.
- d_req  in  1  data request; held until d_gnt is seen.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store completed.
- d_rdata  out  DATA_W  load data; 0 for stores.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables; all ones for fetch and load.
- mem_ack  in  1  memory completion, single cycle.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0, including mem_* payload registers.
  - starve_cnt=0.
  - An in-flight transaction is dropped and mem_req falls immediately, without waiting for a clock edge.
  - No rvalid is ever issued for a dropped transaction.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE, at a rising edge:
  - If a winner exists, latch its payload into the mem_* registers and set mem_req=1.
  - In the same edge, pulse the winner's gnt high for exactly one cycle.
  - Go to BUSY_IF or BUSY_D according to the winner.
  - Base priority: d_req wins over if_req.
  - No request: stay in IDLE, all pulses 0.
- BUSY_x:
  - mem_* stays stable; new requests are not accepted and no gnt is issued.
  - On an edge with mem_ack=1:
    - Capture mem_rdata into the owner's rdata register.
    - Pulse the owner's rvalid for one cycle.
    - Clear mem_req and return to IDLE.
  - For stores, d_rdata is 0 and d_rvalid still pulses.
- Latency:
  - req high in cycle N (IDLE) gives gnt and mem_req in cycle N+1.
  - mem_ack in cycle M gives rvalid in M+1.
  - The next grant comes no earlier than M+2, because of the mandatory IDLE cycle.
  - Minimum turnaround is 3 cycles per transaction.
- Boundary rules:
  - mem_ack while in IDLE is ignored.
  - mem_ack in the same cycle mem_req first rises is valid and accepted.
  - A requester that drops req before gnt has withdrawn its request; no grant is issued.
  - A requester must not reassert req for a new transaction until it has seen its rvalid.
  - if_rdata and d_rdata hold their last value between rvalid pulses.
  - rdata registers are independent; a data transaction never corrupts if_rdata.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - starve_cnt (width clog2(STARVE_MAX+1)) increments, saturating, on each data grant issued while if_req=1.
  - It clears to 0 on any fetch grant.
  - In IDLE, if both requests are high and starve_cnt==STARVE_MAX, fetch wins.
- Undefined:
  - Strict data priority; starve_cnt is not implemented.
  - Fetch can starve indefinitely.

Test Plan:
- Reset with all requests low: release rst, hold 10 cycles -> all outputs remain 0; state IDLE.
- Single fetch, if_addr=0x0000_0010, memory returns 0x0050_0093 two cycles after mem_req:
  - if_gnt pulses 1 cycle after if_req.
  - mem_addr=0x10, mem_be=0xF, mem_we=0.
  - if_rvalid and if_rdata=0x0050_0093 one cycle after mem_ack.
- Simultaneous if_req and d_req (store, addr 0x100, wdata 0xDEAD_BEEF, be 0x3):
  - d_gnt first; mem_we=1, mem_be=0x3.
  - d_rvalid with d_rdata=0.
  - Fetch granted 2 cycles after mem_ack.
- Reset mid-transaction: rst=0 while in BUSY_D with mem_req=1 -> mem_req drops without a clock edge; no d_rvalid after release; next if_req is served normally.
- Starvation:
  - With ARB_STARVE_GUARD_EN and STARVE_MAX=4, hold if_req and d_req continuously -> pattern D,D,D,D,IF,D,D,D,D,IF.
  - Without the macro -> only data grants.
- Spurious mem_ack in IDLE for 3 cycles -> no rvalid pulses; rdata registers unchanged.
